// File: rtl/spi_slave_interface.sv
// SPI slave: oversamples SCK/CS/MOSI on I_clk, receives and transmits bytes MSB-first
// in all four CPOL/CPHA modes, with a one-entry TX holding register and frame status pulses.
module spi_slave_interface #(
  parameter logic       C_CS_ACTIVE     = 1'b0,
  parameter logic [7:0] C_TX_DEFAULT    = 8'hFF,
  parameter logic       C_MISO_DEFLEVEL = 1'b0,
  parameter int         C_SYNC_STAGES   = 2
) (
  input  logic       I_clk,
  input  logic       I_rst_n,
  input  logic       I_cpol,
  input  logic       I_cpha,
  input  logic [7:0] I_tx_data,
  input  logic       I_tx_v,
  output logic       O_tx_ready,
  output logic       O_tx_underrun,
  output logic [7:0] O_rdata,
  output logic       O_rdata_v,
  output logic       O_frame_start,
  output logic       O_frame_end,
  output logic       O_frame_err,
  output logic       O_busy,
  input  logic       I_spi_sck,
  input  logic       I_spi_cs,
  input  logic       I_spi_mosi,
  output logic       O_spi_miso,
  output logic       O_spi_miso_oe
);

  typedef enum logic [1:0] {S_WAIT_IDLE, S_IDLE, S_ACTIVE} state_t;

  state_t                   state;
  logic [C_SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
  logic                     sck_d;
  logic                     sck_s, cs_s, mosi_s, cs_act;
  logic                     sck_edge, lead, trail, sample_stb, shift_stb;
  logic                     cpol_q, cpha_q;
  logic [2:0]               bit_cnt;
  logic [7:0]               rx_sh;
  logic [6:0]               tx_sh;
  logic                     rdata_pend;
  logic [7:0]               hold_q;
  logic                     hold_full;
  logic [7:0]               tx_next;
  logic                     start, load_act, consume, write_en;

  // CS sync resets to the active level so a frame in progress at reset is
  // never mistaken for an idle bus.
  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      sck_sync  <= '0;
      cs_sync   <= {C_SYNC_STAGES{C_CS_ACTIVE}};
      mosi_sync <= '0;
      sck_d     <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[C_SYNC_STAGES-2:0], I_spi_sck};
      cs_sync   <= {cs_sync[C_SYNC_STAGES-2:0], I_spi_cs};
      mosi_sync <= {mosi_sync[C_SYNC_STAGES-2:0], I_spi_mosi};
      sck_d     <= sck_sync[C_SYNC_STAGES-1];
    end
  end

  assign sck_s      = sck_sync[C_SYNC_STAGES-1];
  assign cs_s       = cs_sync[C_SYNC_STAGES-1];
  assign mosi_s     = mosi_sync[C_SYNC_STAGES-1];
  assign cs_act     = (cs_s == C_CS_ACTIVE);
  assign sck_edge   = sck_s ^ sck_d;
  assign lead       = sck_edge && (sck_s != cpol_q);
  assign trail      = sck_edge && (sck_s == cpol_q);
  assign sample_stb = cpha_q ? trail : lead;
  assign shift_stb  = cpha_q ? lead : trail;

  assign tx_next  = hold_full ? hold_q : C_TX_DEFAULT;
  assign start    = (state == S_IDLE) && cs_act;
  // A shift strobe at bit count 0 is always a byte boundary: in CPHA=0 it is the
  // trailing edge after the 8th sample, in CPHA=1 the first leading edge of a byte.
  assign load_act = (state == S_ACTIVE) && cs_act && shift_stb && (bit_cnt == 3'd0);
  // CPHA=1 frames load on the first leading edge, so frame start must not consume.
  assign consume  = (start && !I_cpha) || load_act;
  // A write coinciding with a consume refills the register; the consume takes the old byte.
  assign write_en = I_tx_v && (!hold_full || consume);
  assign O_tx_ready = !hold_full;

  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      hold_q    <= '0;
      hold_full <= 1'b0;
    end else if (write_en) begin
      hold_q    <= I_tx_data;
      hold_full <= 1'b1;
    end else if (consume) begin
      hold_full <= 1'b0;
    end
  end

  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      state         <= S_WAIT_IDLE;
      cpol_q        <= 1'b0;
      cpha_q        <= 1'b0;
      bit_cnt       <= '0;
      rx_sh         <= '0;
      tx_sh         <= '0;
      rdata_pend    <= 1'b0;
      O_rdata       <= '0;
      O_rdata_v     <= 1'b0;
      O_frame_start <= 1'b0;
      O_frame_end   <= 1'b0;
      O_frame_err   <= 1'b0;
      O_tx_underrun <= 1'b0;
      O_busy        <= 1'b0;
      O_spi_miso    <= C_MISO_DEFLEVEL;
      O_spi_miso_oe <= 1'b0;
    end else begin
      O_rdata_v     <= rdata_pend;
      rdata_pend    <= 1'b0;
      O_frame_start <= 1'b0;
      O_frame_end   <= 1'b0;
      O_frame_err   <= 1'b0;
      O_tx_underrun <= consume && !hold_full;
      if (rdata_pend)
        O_rdata <= rx_sh;

      case (state)
        S_WAIT_IDLE: begin
          if (!cs_act)
            state <= S_IDLE;
        end

        S_IDLE: begin
          if (cs_act) begin
            cpol_q        <= I_cpol;
            cpha_q        <= I_cpha;
            bit_cnt       <= '0;
            O_frame_start <= 1'b1;
            O_spi_miso_oe <= 1'b1;
            O_busy        <= 1'b1;
            state         <= S_ACTIVE;
            if (!I_cpha) begin
              tx_sh      <= tx_next[6:0];
              O_spi_miso <= tx_next[7];
            end
          end
        end

        S_ACTIVE: begin
          if (!cs_act) begin
            O_frame_end   <= 1'b1;
            O_frame_err   <= (bit_cnt != 3'd0);
            O_spi_miso_oe <= 1'b0;
            O_spi_miso    <= C_MISO_DEFLEVEL;
            O_busy        <= 1'b0;
            state         <= S_IDLE;
          end else begin
            if (sample_stb) begin
              rx_sh   <= {rx_sh[6:0], mosi_s};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7)
                rdata_pend <= 1'b1;
            end
            if (shift_stb) begin
              if (bit_cnt == 3'd0) begin
                tx_sh      <= tx_next[6:0];
                O_spi_miso <= tx_next[7];
              end else begin
                tx_sh      <= {tx_sh[5:0], 1'b0};
                O_spi_miso <= tx_sh[6];
              end
            end
          end
        end

        default: state <= S_WAIT_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_interface.sv
// Self-checking bench for spi_slave_interface: a behavioural SPI master drives frames
// in all modes; received and transmitted bytes are compared with a byte-queue model.
module tb_spi_slave_interface;

  localparam int HALF_MIN = 4;
  localparam int HALF     = 6;

  logic       I_clk = 1'b0, I_rst_n = 1'b0, I_cpol = 1'b0, I_cpha = 1'b0;
  logic [7:0] I_tx_data = '0;
  logic       I_tx_v = 1'b0;
  logic       I_spi_sck = 1'b0, I_spi_cs = 1'b1, I_spi_mosi = 1'b0;
  logic       O_tx_ready, O_tx_underrun, O_rdata_v, O_frame_start, O_frame_end;
  logic       O_frame_err, O_busy, O_spi_miso, O_spi_miso_oe;
  logic [7:0] O_rdata;

  spi_slave_interface dut (
    .I_clk(I_clk), .I_rst_n(I_rst_n), .I_cpol(I_cpol), .I_cpha(I_cpha),
    .I_tx_data(I_tx_data), .I_tx_v(I_tx_v), .O_tx_ready(O_tx_ready),
    .O_tx_underrun(O_tx_underrun), .O_rdata(O_rdata), .O_rdata_v(O_rdata_v),
    .O_frame_start(O_frame_start), .O_frame_end(O_frame_end), .O_frame_err(O_frame_err),
    .O_busy(O_busy), .I_spi_sck(I_spi_sck), .I_spi_cs(I_spi_cs), .I_spi_mosi(I_spi_mosi),
    .O_spi_miso(O_spi_miso), .O_spi_miso_oe(O_spi_miso_oe)
  );

  always #5 I_clk = ~I_clk;

  int n_checks = 0, n_fail = 0;
  int cnt_rv = 0, cnt_fs = 0, cnt_fe = 0, cnt_err = 0, cnt_ur = 0, oe_bad = 0;
  logic [7:0] rd_q[$];
  logic [7:0] mosi_bytes[$];
  logic [7:0] miso_bytes[$];
  logic [7:0] exp_tx[$];
  logic [7:0] miso_acc;
  int         miso_n;

  always @(negedge I_clk) begin
    if (I_rst_n) begin
      if (O_rdata_v) begin cnt_rv++; rd_q.push_back(O_rdata); end
      if (O_frame_start) cnt_fs++;
      if (O_frame_end)   cnt_fe++;
      if (O_frame_err)   cnt_err++;
      if (O_tx_underrun) cnt_ur++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic clear_mon();
    cnt_rv = 0; cnt_fs = 0; cnt_fe = 0; cnt_err = 0; cnt_ur = 0; oe_bad = 0;
    rd_q.delete();
  endtask

  task automatic capture_miso();
    if (O_spi_miso_oe !== 1'b1) oe_bad++;
    miso_acc = {miso_acc[6:0], O_spi_miso};
    miso_n++;
    if (miso_n == 8) begin miso_bytes.push_back(miso_acc); miso_n = 0; end
  endtask

  // One master bit; the master samples MISO on the edge opposite to its own shift edge.
  task automatic spi_bit(input bit cpol, input bit cpha, input bit b, input int half);
    if (!cpha) begin
      I_spi_mosi = b;
      repeat (half) @(negedge I_clk);
      capture_miso();
      I_spi_sck = ~cpol;
      repeat (half) @(negedge I_clk);
      I_spi_sck = cpol;
    end else begin
      I_spi_sck = ~cpol;
      I_spi_mosi = b;
      repeat (half) @(negedge I_clk);
      capture_miso();
      I_spi_sck = cpol;
      repeat (half) @(negedge I_clk);
    end
  endtask

  task automatic spi_frame(input bit cpol, input bit cpha, input int nbits, input int half);
    logic [7:0] t;
    @(negedge I_clk);
    I_cpol = cpol; I_cpha = cpha; I_spi_sck = cpol;
    repeat (4) @(negedge I_clk);
    I_spi_cs = 1'b0;
    repeat (8) @(negedge I_clk);
    miso_bytes.delete(); miso_n = 0;
    for (int i = 0; i < nbits; i++) begin
      t = mosi_bytes[i/8];
      spi_bit(cpol, cpha, t[7-(i%8)], half);
    end
    repeat (half + 2) @(negedge I_clk);
    I_spi_cs = 1'b1;
    repeat (12) @(negedge I_clk);
  endtask

  task automatic tx_write(input logic [7:0] d);
    I_tx_data = d; I_tx_v = 1'b1;
    @(negedge I_clk);
    I_tx_v = 1'b0;
  endtask

  task automatic test_reset();
    I_rst_n = 1'b0;
    repeat (4) @(negedge I_clk);
    I_rst_n = 1'b1;
    @(negedge I_clk);
    n_checks++; if (O_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata got=%h exp=00", O_rdata); end
    n_checks++; if (O_rdata_v !== 1'b0) begin n_fail++; $display("FAIL reset_rdata_v got=%b exp=0", O_rdata_v); end
    n_checks++; if (O_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", O_busy); end
    n_checks++; if (O_spi_miso_oe !== 1'b0) begin n_fail++; $display("FAIL reset_oe got=%b exp=0", O_spi_miso_oe); end
    n_checks++; if (O_spi_miso !== 1'b0) begin n_fail++; $display("FAIL reset_miso got=%b exp=0", O_spi_miso); end
    n_checks++; if (O_tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_tx_ready got=%b exp=1", O_tx_ready); end
    n_checks++; if ({O_frame_start, O_frame_end, O_frame_err, O_tx_underrun} !== 4'b0) begin
      n_fail++; $display("FAIL reset_pulses got=%b exp=0000", {O_frame_start, O_frame_end, O_frame_err, O_tx_underrun}); end
    repeat (6) @(negedge I_clk);
  endtask

  task automatic test_mode0();
    clear_mon();
    tx_write(8'hA5);
    n_checks++; if (O_tx_ready !== 1'b0) begin n_fail++; $display("FAIL m0_ready_after_write got=%b exp=0", O_tx_ready); end
    mosi_bytes = '{8'h3C};
    spi_frame(1'b0, 1'b0, 8, HALF);
    n_checks++; if (miso_bytes.size() != 1 || miso_bytes[0] !== 8'hA5) begin
      n_fail++; $display("FAIL m0_miso got=%h n=%0d exp=a5", miso_bytes.size() ? miso_bytes[0] : 8'h00, miso_bytes.size()); end
    n_checks++; if (cnt_rv != 1 || rd_q[0] !== 8'h3C) begin
      n_fail++; $display("FAIL m0_rdata got=%h n=%0d exp=3c n=1", rd_q.size() ? rd_q[0] : 8'h00, cnt_rv); end
    n_checks++; if (cnt_fs != 1 || cnt_fe != 1) begin n_fail++; $display("FAIL m0_frame_pulses fs=%0d fe=%0d exp=1,1", cnt_fs, cnt_fe); end
    n_checks++; if (cnt_err != 0) begin n_fail++; $display("FAIL m0_frame_err got=%0d exp=0", cnt_err); end
    n_checks++; if (oe_bad != 0) begin n_fail++; $display("FAIL m0_oe_in_frame bad=%0d exp=0", oe_bad); end
    n_checks++; if (O_spi_miso_oe !== 1'b0 || O_busy !== 1'b0) begin
      n_fail++; $display("FAIL m0_idle_after oe=%b busy=%b exp=0,0", O_spi_miso_oe, O_busy); end
  endtask

  task automatic test_mode3_burst();
    int  t;
    bit  to;
    logic [7:0] e;
    clear_mon();
    exp_tx = '{8'h5A, 8'hC3};
    tx_write(8'h5A);
    mosi_bytes = '{8'h11, 8'h22, 8'h33};
    to = 1'b0;
    fork
      spi_frame(1'b1, 1'b1, 24, HALF);
      begin
        t = 0;
        while (O_tx_ready !== 1'b1 && t < 2000) begin @(negedge I_clk); t++; end
        if (t >= 2000) to = 1'b1; else tx_write(8'hC3);
      end
    join
    n_checks++; if (to) begin n_fail++; $display("FAIL m3_wait_ready timeout got=1 exp=0"); end
    n_checks++; if (miso_bytes.size() != 3) begin n_fail++; $display("FAIL m3_miso_count got=%0d exp=3", miso_bytes.size()); end
    for (int k = 0; k < 3 && k < miso_bytes.size(); k++) begin
      e = (k < exp_tx.size()) ? exp_tx[k] : 8'hFF;
      n_checks++; if (miso_bytes[k] !== e) begin n_fail++; $display("FAIL m3_miso[%0d] got=%h exp=%h", k, miso_bytes[k], e); end
    end
    n_checks++; if (cnt_ur != 1) begin n_fail++; $display("FAIL m3_underrun got=%0d exp=1", cnt_ur); end
    n_checks++; if (cnt_rv != 3) begin n_fail++; $display("FAIL m3_rdata_v got=%0d exp=3", cnt_rv); end
    for (int k = 0; k < 3 && k < rd_q.size(); k++) begin
      n_checks++; if (rd_q[k] !== mosi_bytes[k]) begin n_fail++; $display("FAIL m3_rdata[%0d] got=%h exp=%h", k, rd_q[k], mosi_bytes[k]); end
    end
  endtask

  task automatic test_random_modes();
    logic [7:0] tb_t, tb_r;
    bit cp, ch;
    for (int m = 0; m < 4; m++) begin
      for (int it = 0; it < 2; it++) begin
        cp = 1'((m >> 1) & 1);
        ch = 1'(m & 1);
        tb_t = 8'($urandom);
        tb_r = 8'($urandom);
        clear_mon();
        tx_write(tb_t);
        mosi_bytes = '{tb_r};
        spi_frame(cp, ch, 8, HALF_MIN);
        n_checks++; if (miso_bytes.size() != 1 || miso_bytes[0] !== tb_t) begin
          n_fail++; $display("FAIL rnd_mode%0d_miso got=%h exp=%h", m, miso_bytes.size() ? miso_bytes[0] : 8'h00, tb_t); end
        n_checks++; if (cnt_rv != 1 || rd_q[0] !== tb_r) begin
          n_fail++; $display("FAIL rnd_mode%0d_rdata got=%h n=%0d exp=%h", m, rd_q.size() ? rd_q[0] : 8'h00, cnt_rv, tb_r); end
      end
    end
  endtask

  task automatic test_frame_err();
    clear_mon();
    mosi_bytes = '{8'hB0};
    spi_frame(1'b0, 1'b0, 5, HALF);
    n_checks++; if (cnt_err != 1) begin n_fail++; $display("FAIL ferr_pulse got=%0d exp=1", cnt_err); end
    n_checks++; if (cnt_rv != 0) begin n_fail++; $display("FAIL ferr_no_rdata got=%0d exp=0", cnt_rv); end
    n_checks++; if (cnt_fe != 1) begin n_fail++; $display("FAIL ferr_frame_end got=%0d exp=1", cnt_fe); end
    clear_mon();
    mosi_bytes = '{8'h81};
    spi_frame(1'b0, 1'b0, 8, HALF);
    n_checks++; if (cnt_rv != 1 || rd_q[0] !== 8'h81) begin
      n_fail++; $display("FAIL ferr_next_rdata got=%h n=%0d exp=81", rd_q.size() ? rd_q[0] : 8'h00, cnt_rv); end
    n_checks++; if (cnt_err != 0) begin n_fail++; $display("FAIL ferr_next_err got=%0d exp=0", cnt_err); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b = 8'hC9;
    clear_mon();
    @(negedge I_clk);
    I_cpol = 1'b0; I_cpha = 1'b0; I_spi_sck = 1'b0;
    repeat (4) @(negedge I_clk);
    I_spi_cs = 1'b0;
    repeat (8) @(negedge I_clk);
    for (int i = 0; i < 3; i++) spi_bit(1'b0, 1'b0, b[7-i], HALF);
    I_rst_n = 1'b0;
    repeat (2) @(negedge I_clk);
    I_rst_n = 1'b1;
    @(negedge I_clk);
    n_checks++; if (O_rdata !== 8'h00) begin n_fail++; $display("FAIL rstmid_rdata got=%h exp=00", O_rdata); end
    n_checks++; if (O_spi_miso_oe !== 1'b0 || O_busy !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_oe_busy oe=%b busy=%b exp=0,0", O_spi_miso_oe, O_busy); end
    n_checks++; if (O_tx_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready got=%b exp=1", O_tx_ready); end
    clear_mon();
    for (int i = 3; i < 8; i++) spi_bit(1'b0, 1'b0, b[7-i], HALF);
    repeat (8) @(negedge I_clk);
    n_checks++; if (cnt_rv != 0 || cnt_fs != 0) begin
      n_fail++; $display("FAIL rstmid_ignored rv=%0d fs=%0d exp=0,0", cnt_rv, cnt_fs); end
    n_checks++; if (O_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got=%b exp=0", O_busy); end
    I_spi_cs = 1'b1;
    repeat (10) @(negedge I_clk);
    clear_mon();
    mosi_bytes = '{8'h7E};
    spi_frame(1'b0, 1'b0, 8, HALF);
    n_checks++; if (cnt_rv != 1 || rd_q[0] !== 8'h7E) begin
      n_fail++; $display("FAIL rstmid_next_rdata got=%h n=%0d exp=7e", rd_q.size() ? rd_q[0] : 8'h00, cnt_rv); end
    n_checks++; if (cnt_fs != 1) begin n_fail++; $display("FAIL rstmid_next_fs got=%0d exp=1", cnt_fs); end
  endtask

  task automatic test_back_to_back();
    int t;
    bit to, rdy_seen;
    logic [7:0] e;
    clear_mon();
    exp_tx = '{8'h96, 8'h4B, 8'hD2};
    tx_write(8'h96);
    mosi_bytes = '{8'h5C, 8'hE1, 8'h07};
    to = 1'b0; rdy_seen = 1'b0;
    fork
      spi_frame(1'b0, 1'b1, 24, HALF);
      begin
        t = 0;
        while (O_tx_ready !== 1'b1 && t < 2000) begin @(negedge I_clk); t++; end
        if (t >= 2000) to = 1'b1;
        else begin
          tx_write(8'h4B);
          I_tx_data = 8'hD2; I_tx_v = 1'b1;
          t = 0;
          while (cnt_rv < 2 && t < 3000) begin
            @(negedge I_clk); t++;
            if (O_tx_ready === 1'b1) rdy_seen = 1'b1;
          end
          if (t >= 3000) to = 1'b1;
          I_tx_v = 1'b0;
        end
      end
    join
    n_checks++; if (to) begin n_fail++; $display("FAIL b2b_wait timeout got=1 exp=0"); end
    n_checks++; if (rdy_seen) begin n_fail++; $display("FAIL b2b_ready_stayed_low got=1 exp=0"); end
    n_checks++; if (miso_bytes.size() != 3) begin n_fail++; $display("FAIL b2b_miso_count got=%0d exp=3", miso_bytes.size()); end
    for (int k = 0; k < 3 && k < miso_bytes.size(); k++) begin
      e = (k < exp_tx.size()) ? exp_tx[k] : 8'hFF;
      n_checks++; if (miso_bytes[k] !== e) begin n_fail++; $display("FAIL b2b_miso[%0d] got=%h exp=%h", k, miso_bytes[k], e); end
    end
    n_checks++; if (cnt_ur != 0) begin n_fail++; $display("FAIL b2b_underrun got=%0d exp=0", cnt_ur); end
    n_checks++; if (cnt_rv != 3) begin n_fail++; $display("FAIL b2b_rdata_v got=%0d exp=3", cnt_rv); end
    n_checks++; if (O_tx_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_end got=%b exp=1", O_tx_ready); end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_mode3_burst();
    test_random_modes();
    test_frame_err();
    test_reset_midframe();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
